arm7tdmi_write_buffer: RTL and testbench

- Posted-write buffer between the MMU physical-side port (mem_*) and the external memory / bus.
- Accepts physical transactions from the MMU. Bufferable writes are queued in a FIFO and completed to the MMU immediately; reads and non-bufferable writes drain the FIFO first, then go directly to memory.
- Exposes empty and status flags for the CP15 "drain write buffer" operation.

---
 rtl/arm7tdmi_pkg.sv | 23 ++
 rtl/arm7tdmi_wb_fifo.sv | 51 +++++
 rtl/arm7tdmi_write_buffer.sv | 137 +++++++++++++
 tb/tb_arm7tdmi_write_buffer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/arm7tdmi_pkg.sv
// rtl/arm7tdmi_pkg.sv - shared types for the ARM7TDMI posted-write buffer
package arm7tdmi_pkg;

  localparam int PADDR_MAX = 32;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef struct packed {
    logic [PADDR_MAX-1:0] paddr;
    logic [1:0]           size;
    logic [31:0]          wdata;
  } wb_entry_t;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_DRAIN,
    DIRECT,
    RESP
  } wb_state_t;

endpackage

// File: rtl/arm7tdmi_wb_fifo.sv
// rtl/arm7tdmi_wb_fifo.sv - synchronous FIFO of posted write entries
module arm7tdmi_wb_fifo
  import arm7tdmi_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  wb_entry_t     push_data,
  input  logic          pop,
  output wb_entry_t     head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  wb_entry_t     mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers are exactly log2(DEPTH) wide, so they wrap modulo DEPTH by themselves.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/arm7tdmi_write_buffer.sv
// rtl/arm7tdmi_write_buffer.sv - posted-write buffer between MMU physical port and memory
module arm7tdmi_write_buffer
  import arm7tdmi_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ADDR_WIDTH = 32,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] up_paddr,
  input  logic                  up_req,
  input  logic                  up_write,
  input  logic [1:0]            up_size,
  input  logic [31:0]           up_wdata,
  input  logic                  up_bufferable,
  output logic [31:0]           up_rdata,
  output logic                  up_ready,
  output logic                  up_abort,
  output logic [ADDR_WIDTH-1:0] dn_paddr,
  output logic                  dn_req,
  output logic                  dn_write,
  output logic [1:0]            dn_size,
  output logic [31:0]           dn_wdata,
  input  logic [31:0]           dn_rdata,
  input  logic                  dn_ready,
  input  logic                  dn_abort,
  output logic                  wb_empty,
  output logic [CW-1:0]         wb_count,
  output logic                  wb_error,
  input  logic                  wb_error_clr
);

  wb_state_t state;
  wb_entry_t hold;
  wb_entry_t head;
  wb_entry_t up_entry;
  logic      hold_write;
  logic      resp_abort;
  logic      fifo_empty;
  logic      fifo_full;
  logic      direct;
  logic      drain;
  logic      pop;
  logic      push;
  logic      accept_ok;

  assign up_entry  = '{paddr: PADDR_MAX'(up_paddr), size: up_size, wdata: up_wdata};
  assign direct    = (state == DIRECT);
  assign drain     = !fifo_empty && !direct;
  assign pop       = drain && dn_ready;
  // Blocking acceptance while a response pulse is out keeps a held request from being taken twice.
  assign accept_ok = (state == IDLE) && up_req && !up_ready && !up_abort;
  assign push      = accept_ok && up_write && up_bufferable && !fifo_full;

  arm7tdmi_wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (up_entry),
    .pop       (pop),
    .head      (head),
    .count     (wb_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign wb_empty = fifo_empty;

  // Memory side is a mux of registered state only; nothing from up_* reaches it directly.
  always_comb begin
    dn_req   = 1'b0;
    dn_write = 1'b0;
    dn_paddr = '0;
    dn_size  = '0;
    dn_wdata = '0;
    if (direct) begin
      dn_req   = 1'b1;
      dn_write = hold_write;
      dn_paddr = ADDR_WIDTH'(hold.paddr);
      dn_size  = hold.size;
      dn_wdata = hold.wdata;
    end else if (drain) begin
      dn_req   = 1'b1;
      dn_write = 1'b1;
      dn_paddr = ADDR_WIDTH'(head.paddr);
      dn_size  = head.size;
      dn_wdata = head.wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold       <= '0;
      hold_write <= 1'b0;
      resp_abort <= 1'b0;
      up_ready   <= 1'b0;
      up_abort   <= 1'b0;
      up_rdata   <= '0;
      wb_error   <= 1'b0;
    end else begin
      up_ready <= 1'b0;
      up_abort <= 1'b0;
      if (pop && dn_abort)   wb_error <= 1'b1;
      else if (wb_error_clr) wb_error <= 1'b0;
      case (state)
        IDLE: begin
          if (push) begin
            up_ready <= 1'b1;
          end else if (accept_ok && !(up_write && up_bufferable)) begin
            hold       <= up_entry;
            hold_write <= up_write;
            state      <= fifo_empty ? DIRECT : WAIT_DRAIN;
          end
        end
        WAIT_DRAIN: begin
          if (fifo_empty) state <= DIRECT;
        end
        DIRECT: begin
          if (dn_ready) begin
            resp_abort <= dn_abort;
            if (!hold_write && !dn_abort) up_rdata <= dn_rdata;
            state <= RESP;
          end
        end
        RESP: begin
          up_ready <= !resp_abort;
          up_abort <= resp_abort;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_arm7tdmi_write_buffer.sv
// tb/tb_arm7tdmi_write_buffer.sv - scoreboard bench: program-order memory model vs write buffer
module tb_arm7tdmi_write_buffer;
  import arm7tdmi_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW = 32;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] up_paddr = '0;
  logic          up_req = 1'b0;
  logic          up_write = 1'b0;
  logic [1:0]    up_size = '0;
  logic [31:0]   up_wdata = '0;
  logic          up_bufferable = 1'b0;
  logic [31:0]   up_rdata;
  logic          up_ready;
  logic          up_abort;
  logic [AW-1:0] dn_paddr;
  logic          dn_req;
  logic          dn_write;
  logic [1:0]    dn_size;
  logic [31:0]   dn_wdata;
  logic [31:0]   dn_rdata = '0;
  logic          dn_ready = 1'b0;
  logic          dn_abort = 1'b0;
  logic          wb_empty;
  logic [CW-1:0] wb_count;
  logic          wb_error;
  logic          wb_error_clr = 1'b0;

  arm7tdmi_write_buffer #(.DEPTH(DEPTH), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .up_paddr(up_paddr), .up_req(up_req), .up_write(up_write), .up_size(up_size),
    .up_wdata(up_wdata), .up_bufferable(up_bufferable), .up_rdata(up_rdata),
    .up_ready(up_ready), .up_abort(up_abort),
    .dn_paddr(dn_paddr), .dn_req(dn_req), .dn_write(dn_write), .dn_size(dn_size),
    .dn_wdata(dn_wdata), .dn_rdata(dn_rdata), .dn_ready(dn_ready), .dn_abort(dn_abort),
    .wb_empty(wb_empty), .wb_count(wb_count), .wb_error(wb_error), .wb_error_clr(wb_error_clr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fails  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Every request must reach memory exactly once, in program order; bit 31 marks an aborting region.
  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] sim_mem [logic [31:0]];
  logic [31:0] ref_mem [logic [31:0]];
  int          stall_cycles = 0;
  bit          hold_low = 1'b0;
  bit          rand_stall = 1'b0;
  int          wait_cnt = 0;

  function automatic logic [31:0] sim_rd(input logic [31:0] a);
    return sim_mem.exists(a) ? sim_mem[a] : ~a;
  endfunction

  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : ~a;
  endfunction

  always @(negedge clk) begin
    txn_t e;
    dn_ready = 1'b0;
    if (!rst_n || !dn_req || hold_low) begin
      wait_cnt = 0;
    end else if (wait_cnt >= stall_cycles) begin
      dn_ready = 1'b1;
      wait_cnt = 0;
      check_eq("dn_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_eq("dn_cmd", {dn_write, dn_size, dn_paddr}, {e.wr, e.size, e.addr});
        if (e.wr) check_eq("dn_wdata", dn_wdata, e.data);
      end
      if (dn_write && !dn_paddr[31]) sim_mem[dn_paddr] = dn_wdata;
      if (rand_stall) stall_cycles = $urandom_range(0, 2);
    end else begin
      wait_cnt++;
    end
    dn_abort = dn_ready && dn_paddr[31];
    dn_rdata = (dn_ready && !dn_write) ? sim_rd(dn_paddr) : 32'hDEAD_BEEF;
  end

  task automatic req_start(input bit wr, input bit bufd, input logic [31:0] a,
                           input logic [1:0] sz, input logic [31:0] d);
    txn_t t;
    @(negedge clk);
    up_req = 1'b1; up_write = wr; up_bufferable = bufd;
    up_paddr = a; up_size = sz; up_wdata = d;
    t.wr = wr; t.size = sz; t.addr = a; t.data = d;
    exp_q.push_back(t);
    if (wr && !a[31]) ref_mem[a] = d;
  endtask

  // The request stays up through the response cycle, as the MMU only drops it after seeing the pulse.
  task automatic req_wait(output logic [31:0] rd, output bit ab, output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!up_ready && !up_abort && lat < 300);
    check_eq("req_done", 64'(up_ready | up_abort), 64'd1);
    rd = up_rdata;
    ab = up_abort;
    @(posedge clk); #1;
    up_req = 1'b0;
  endtask

  task automatic wait_empty();
    int n = 0;
    while (!wb_empty && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check_eq("drain_done", 64'(wb_empty), 64'd1);
  endtask

  logic [31:0] rd;
  bit          ab;
  int          lat;
  bit          exp_err;

  initial begin
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_up_ready", up_ready, 0);
    check_eq("rst_up_abort", up_abort, 0);
    check_eq("rst_up_rdata", up_rdata, 0);
    check_eq("rst_dn_req", dn_req, 0);
    check_eq("rst_dn_bus", {dn_paddr, dn_wdata, dn_write, dn_size}, 0);
    check_eq("rst_wb_count", wb_count, 0);
    check_eq("rst_wb_empty", wb_empty, 1);
    check_eq("rst_wb_error", wb_error, 0);
    @(negedge clk) rst_n = 1'b1;

    // single posted write, then read-back latency on an empty buffer
    req_start(1, 1, 32'h0030_1000, SIZE_WORD, 32'hABCD_EF00);
    req_wait(rd, ab, lat);
    check_eq("post_lat", lat, 1);
    wait_empty();
    req_start(0, 0, 32'h0030_1000, SIZE_WORD, 32'h0);
    req_wait(rd, ab, lat);
    check_eq("read_lat", lat, 3);
    check_eq("read_data", rd, 32'hABCD_EF00);

    // fill the buffer with memory stalled; the fifth write waits for the first pop
    hold_low = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_start(1, 1, 32'h0030_4000 + 32'(i * 4), SIZE_WORD, 32'h5000_0000 + 32'(i));
      req_wait(rd, ab, lat);
      check_eq("fill_lat", lat, 1);
    end
    check_eq("fill_count", wb_count, 4);
    req_start(1, 1, 32'h0030_4010, SIZE_HALF, 32'h5000_0004);
    repeat (4) @(posedge clk);
    #1;
    check_eq("full_stall", {up_ready, up_abort}, 0);
    check_eq("full_count", wb_count, 4);
    hold_low = 1'b0;
    req_wait(rd, ab, lat);
    check_eq("full_ack_abort", ab, 0);
    wait_empty();

    // read after write to the same address with a slow memory: strict ordering, no forwarding
    stall_cycles = 3;
    req_start(1, 1, 32'h0030_2000, SIZE_WORD, 32'h1111_1111);
    req_wait(rd, ab, lat);
    req_start(0, 0, 32'h0030_2000, SIZE_WORD, 32'h0);
    req_wait(rd, ab, lat);
    check_eq("raw_data", rd, 32'h1111_1111);
    stall_cycles = 0;

    // non-bufferable write behind two posted writes completes only after both drain
    hold_low = 1'b1;
    req_start(1, 1, 32'h0030_3000, SIZE_BYTE, 32'h0000_00A1);
    req_wait(rd, ab, lat);
    req_start(1, 1, 32'h0030_3004, SIZE_HALF, 32'h0000_B2B2);
    req_wait(rd, ab, lat);
    req_start(1, 0, 32'h0030_3008, SIZE_WORD, 32'hC3C3_C3C3);
    repeat (4) @(posedge clk);
    #1;
    check_eq("nb_blocked", {up_ready, up_abort}, 0);
    hold_low = 1'b0;
    req_wait(rd, ab, lat);
    check_eq("nb_abort", ab, 0);
    check_eq("nb_all_done", exp_q.size(), 0);

    // aborts: posted write is sticky wb_error, direct read is an up_abort pulse
    req_start(1, 1, 32'h8000_1000, SIZE_WORD, 32'h0BAD_0BAD);
    req_wait(rd, ab, lat);
    check_eq("perr_no_abort", ab, 0);
    wait_empty();
    check_eq("perr_set", wb_error, 1);
    @(negedge clk) wb_error_clr = 1'b1;
    @(negedge clk) wb_error_clr = 1'b0;
    check_eq("perr_clr", wb_error, 0);
    req_start(0, 0, 32'h8000_2000, SIZE_WORD, 32'h0);
    req_wait(rd, ab, lat);
    check_eq("rd_abort", ab, 1);
    check_eq("rd_abort_pulse", {up_ready, up_abort}, 0);

    // asynchronous reset with queued writes discards them
    hold_low = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_start(1, 1, 32'h0050_0000 + 32'(i * 4), SIZE_WORD, 32'h7700_0000 + 32'(i));
      req_wait(rd, ab, lat);
    end
    check_eq("rst_q_count", wb_count, 3);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("arst_count", wb_count, 0);
    check_eq("arst_empty", wb_empty, 1);
    check_eq("arst_dn_req", dn_req, 0);
    exp_q.delete();
    @(negedge clk) rst_n = 1'b1;
    hold_low = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("post_rst_idle", {dn_req, wb_count}, 0);

    // randomized mix against the program-order model
    rand_stall = 1'b1;
    exp_err = 1'b0;
    for (int i = 0; i < 80; i++) begin
      int          kind;
      logic [31:0] a;
      logic [31:0] d;
      logic [31:0] exp_d;
      logic [1:0]  sz;
      kind = $urandom_range(0, 9);
      a = 32'h0000_1000 | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) a[31] = 1'b1;
      d = $urandom;
      sz = 2'($urandom_range(0, 2));
      if (kind < 5) begin
        if (a[31]) exp_err = 1'b1;
        req_start(1, 1, a, sz, d);
        req_wait(rd, ab, lat);
        check_eq("rnd_post_abort", ab, 0);
      end else if (kind < 7) begin
        req_start(1, 0, a, sz, d);
        req_wait(rd, ab, lat);
        check_eq("rnd_nbw_abort", ab, a[31]);
      end else begin
        exp_d = ref_rd(a);
        req_start(0, 0, a, sz, 32'h0);
        req_wait(rd, ab, lat);
        check_eq("rnd_rd_abort", ab, a[31]);
        if (!a[31]) check_eq("rnd_rd_data", rd, exp_d);
      end
    end
    rand_stall = 1'b0;
    stall_cycles = 0;
    wait_empty();
    check_eq("rnd_wb_error", wb_error, exp_err);
    check_eq("rnd_q_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
